// File: rtl/forward_pass_sequencer.sv
// Per-sample forward-pass sequencer for the cached dilated causal conv stack:
// shift -> (start, wait, cache) per layer -> output latch, with headroom stats.
module forward_pass_sequencer #(
    parameter int N_LAYERS = 3,
    parameter int CW       = 16,
    parameter int TIMEOUT  = 1023
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    sample_strobe,
    input  logic [N_LAYERS-1:0]                     conv_out_v,
    output logic                                    lsb_clk,
    output logic [N_LAYERS-1:0]                     conv_rst,
    output logic [(N_LAYERS > 1 ? N_LAYERS-2 : 0):0] cache_clk,
    output logic                                    out_latch,
    output logic                                    busy,
    output logic [CW-1:0]                           pass_cycles,
    output logic [CW-1:0]                           overrun_count,
    output logic                                    timeout_err
);

    localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int CL = (N_LAYERS > 1) ? N_LAYERS - 1 : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_START, S_WAIT, S_CACHE, S_OUTPUT
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] layer_q, layer_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [CW-1:0] pass_cnt_q, pass_cnt_d;
    logic [CW-1:0] pass_cycles_q, pass_cycles_d;
    logic [CW-1:0] overrun_q, overrun_d;
    logic          timeout_err_q, timeout_err_d;
    logic          lsb_clk_q, lsb_clk_d;
    logic          out_latch_q, out_latch_d;
    logic          busy_q, busy_d;
    logic [N_LAYERS-1:0] conv_rst_q, conv_rst_d;
    logic [CL-1:0]       cache_clk_q, cache_clk_d;
    logic                blanking;
    logic                limit_hit;

    // First WAIT cycle ignores out_v: it can still be high from the previous pass.
    assign blanking  = (wait_cnt_q == '0);
    assign limit_hit = (32'(wait_cnt_q) + 32'd1 >= 32'(TIMEOUT));

    always_comb begin
        state_d       = state_q;
        layer_d       = layer_q;
        wait_cnt_d    = wait_cnt_q;
        pass_cycles_d = pass_cycles_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_IDLE: begin
                layer_d = '0;
                if (sample_strobe) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                layer_d = '0;
                state_d = S_START;
            end
            S_START: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + WW'(1);
                if (!blanking && conv_out_v[layer_q]) begin
                    state_d = (layer_q == LW'(N_LAYERS - 1)) ? S_OUTPUT : S_CACHE;
                end else if (limit_hit) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            S_CACHE: begin
                layer_d = layer_q + LW'(1);
                state_d = S_START;
            end
            S_OUTPUT: begin
                pass_cycles_d = pass_cnt_q;
                state_d       = sample_strobe ? S_SHIFT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (sample_strobe && state_q != S_IDLE && state_q != S_OUTPUT && overrun_q != '1)
            overrun_d = overrun_q + CW'(1);

        pass_cnt_d = pass_cnt_q;
        if (state_d == S_SHIFT)
            pass_cnt_d = CW'(1);
        else if (state_d != S_IDLE && pass_cnt_q != '1)
            pass_cnt_d = pass_cnt_q + CW'(1);

        // Pulses are registered from the next state so they align with the state cycle.
        busy_d      = (state_d != S_IDLE);
        lsb_clk_d   = (state_d == S_SHIFT);
        out_latch_d = (state_d == S_OUTPUT);
        for (int i = 0; i < N_LAYERS; i++)
            conv_rst_d[i] = (state_d == S_START) && (layer_d == LW'(i));
        for (int i = 0; i < CL; i++)
            cache_clk_d[i] = (N_LAYERS > 1) && (state_d == S_CACHE) && (layer_d == LW'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            layer_q       <= '0;
            wait_cnt_q    <= '0;
            pass_cnt_q    <= '0;
            pass_cycles_q <= '0;
            overrun_q     <= '0;
            timeout_err_q <= 1'b0;
            lsb_clk_q     <= 1'b0;
            out_latch_q   <= 1'b0;
            busy_q        <= 1'b0;
            conv_rst_q    <= '0;
            cache_clk_q   <= '0;
        end else begin
            state_q       <= state_d;
            layer_q       <= layer_d;
            wait_cnt_q    <= wait_cnt_d;
            pass_cnt_q    <= pass_cnt_d;
            pass_cycles_q <= pass_cycles_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            lsb_clk_q     <= lsb_clk_d;
            out_latch_q   <= out_latch_d;
            busy_q        <= busy_d;
            conv_rst_q    <= conv_rst_d;
            cache_clk_q   <= cache_clk_d;
        end
    end

    assign lsb_clk       = lsb_clk_q;
    assign conv_rst      = conv_rst_q;
    assign cache_clk     = cache_clk_q;
    assign out_latch     = out_latch_q;
    assign busy          = busy_q;
    assign pass_cycles   = pass_cycles_q;
    assign overrun_count = overrun_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_forward_pass_sequencer.sv
// Scoreboard bench: stimulus queues expected pulse events (cycle, kind); a
// negedge monitor pops and compares every pulse the sequencer emits.
module tb_forward_pass_sequencer;

    localparam int NL = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_strobe;
    logic [NL-1:0] conv_out_v;
    logic          lsb_clk;
    logic [NL-1:0] conv_rst;
    logic [NL-2:0] cache_clk;
    logic          out_latch;
    logic          busy;
    logic [CW-1:0] pass_cycles;
    logic [CW-1:0] overrun_count;
    logic          timeout_err;

    forward_pass_sequencer #(.N_LAYERS(NL), .CW(CW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .sample_strobe(sample_strobe), .conv_out_v(conv_out_v),
        .lsb_clk(lsb_clk), .conv_rst(conv_rst), .cache_clk(cache_clk),
        .out_latch(out_latch), .busy(busy), .pass_cycles(pass_cycles),
        .overrun_count(overrun_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // kind: 0 lsb_clk, 1..3 conv_rst[i], 4..5 cache_clk[i], 6 out_latch
    typedef struct { int cyc; int kind; } ev_t;
    ev_t exp_q[$];

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        logic [6:0] pv;
        ev_t e;
        pv = {out_latch, cache_clk, conv_rst, lsb_clk};
        for (int k = 0; k < 7; k++) begin
            if (pv[k] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse: got kind %0d at cycle %0d, expected no pulse", k, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.kind != k) begin
                        errors++;
                        $display("FAIL pulse: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                                 k, cyc, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push(input int c, input int k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        exp_q.push_back(e);
    endtask

    task automatic std_pass(input int t0);
        push(t0 + 1, 0);  push(t0 + 2, 1);  push(t0 + 5, 4);  push(t0 + 6, 2);
        push(t0 + 9, 5);  push(t0 + 10, 3); push(t0 + 13, 6);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic strobe_once();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
    endtask

    initial begin : stim
        int t0;
        int t1;
        rst = 1'b1;
        sample_strobe = 1'b0;
        conv_out_v = 3'b111;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_pass_cycles", int'(pass_cycles), 0);
        chk("rst_overrun", int'(overrun_count), 0);
        chk("rst_timeout", int'(timeout_err), 0);
        chk("rst_pulses", int'({out_latch, cache_clk, conv_rst, lsb_clk}), 0);

        // minimum pass, all valids tied high
        t0 = cyc;
        std_pass(t0);
        strobe_once();
        chk("t1_busy_first", int'(busy), 1);
        run_to(t0 + 13);
        chk("t1_busy_last", int'(busy), 1);
        run_to(t0 + 14);
        chk("t1_busy_after", int'(busy), 0);
        chk("t1_pass_cycles", int'(pass_cycles), 13);

        // layer 1 stalls: WAIT(1) lasts 9 cycles
        t0 = cyc;
        push(t0 + 1, 0); push(t0 + 2, 1); push(t0 + 5, 4); push(t0 + 6, 2);
        push(t0 + 16, 5); push(t0 + 17, 3); push(t0 + 20, 6);
        strobe_once();
        run_to(t0 + 6);
        conv_out_v = 3'b101;
        run_to(t0 + 15);
        conv_out_v = 3'b111;
        run_to(t0 + 21);
        chk("t2_pass_cycles", int'(pass_cycles), 20);

        // stale valid in the blanking cycle must not exit WAIT(0)
        t0 = cyc;
        conv_out_v = 3'b110;
        push(t0 + 1, 0); push(t0 + 2, 1); push(t0 + 9, 4); push(t0 + 10, 2);
        push(t0 + 13, 5); push(t0 + 14, 3); push(t0 + 17, 6);
        strobe_once();
        run_to(t0 + 3);
        conv_out_v = 3'b111;
        run_to(t0 + 4);
        conv_out_v = 3'b110;
        run_to(t0 + 8);
        conv_out_v = 3'b111;
        run_to(t0 + 18);
        chk("t3_pass_cycles", int'(pass_cycles), 17);

        // second strobe mid-pass is dropped and counted
        t0 = cyc;
        std_pass(t0);
        strobe_once();
        run_to(t0 + 5);
        strobe_once();
        run_to(t0 + 14);
        chk("t4_overrun", int'(overrun_count), 1);
        chk("t4_pass_cycles", int'(pass_cycles), 13);
        chk("t4_busy", int'(busy), 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_overrun", int'(overrun_count), 0);
        chk("rst2_pass_cycles", int'(pass_cycles), 0);

        // strobe during OUTPUT chains a back-to-back pass
        t0 = cyc;
        std_pass(t0);
        std_pass(t0 + 13);
        strobe_once();
        run_to(t0 + 13);
        strobe_once();
        run_to(t0 + 27);
        chk("t5_pass_cycles", int'(pass_cycles), 13);
        chk("t5_overrun", int'(overrun_count), 0);
        chk("t5_busy", int'(busy), 0);

        // valid arriving on the 16th WAIT(2) cycle beats the timeout
        t0 = cyc;
        conv_out_v = 3'b011;
        push(t0 + 1, 0); push(t0 + 2, 1); push(t0 + 5, 4); push(t0 + 6, 2);
        push(t0 + 9, 5); push(t0 + 10, 3); push(t0 + 27, 6);
        strobe_once();
        run_to(t0 + 26);
        conv_out_v = 3'b111;
        run_to(t0 + 28);
        chk("t6a_pass_cycles", int'(pass_cycles), 27);
        chk("t6a_timeout", int'(timeout_err), 0);

        // layer 2 never answers: abort after 16 WAIT cycles
        t0 = cyc;
        conv_out_v = 3'b011;
        push(t0 + 1, 0); push(t0 + 2, 1); push(t0 + 5, 4); push(t0 + 6, 2);
        push(t0 + 9, 5); push(t0 + 10, 3);
        strobe_once();
        run_to(t0 + 26);
        chk("t6b_timeout_before", int'(timeout_err), 0);
        chk("t6b_busy_before", int'(busy), 1);
        run_to(t0 + 27);
        chk("t6b_timeout_after", int'(timeout_err), 1);
        chk("t6b_busy_after", int'(busy), 0);
        chk("t6b_pass_unchanged", int'(pass_cycles), 27);
        conv_out_v = 3'b111;
        run_to(t0 + 28);
        t1 = cyc;
        std_pass(t1);
        strobe_once();
        run_to(t1 + 14);
        chk("t6c_pass_cycles", int'(pass_cycles), 13);
        chk("t6c_timeout_sticky", int'(timeout_err), 1);

        // reset with a coincident strobe during WAIT(1)
        t0 = cyc;
        conv_out_v = 3'b101;
        push(t0 + 1, 0); push(t0 + 2, 1); push(t0 + 5, 4); push(t0 + 6, 2);
        strobe_once();
        run_to(t0 + 9);
        rst = 1'b1;
        sample_strobe = 1'b1;
        tick();
        rst = 1'b0;
        sample_strobe = 1'b0;
        conv_out_v = 3'b111;
        chk("t7_busy", int'(busy), 0);
        chk("t7_pass_cycles", int'(pass_cycles), 0);
        chk("t7_overrun", int'(overrun_count), 0);
        chk("t7_timeout", int'(timeout_err), 0);
        chk("t7_pulses", int'({out_latch, cache_clk, conv_rst, lsb_clk}), 0);
        run_to(t0 + 25);
        chk("t7_busy_later", int'(busy), 0);

        run_to(cyc + 2);
        chk("scoreboard_left", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
